// File: rtl/fall_edge_gen.sv
// Falling-edge pulse generator: turns single-cycle triggers into timed active-low
// pulses on an idle-high line, queueing triggers that arrive while a pulse is in flight.
module fall_edge_gen #(
  parameter int unsigned LOW_CYCLES  = 4,
  parameter int unsigned HIGH_CYCLES = 4,
  parameter int unsigned PEND_DEPTH  = 3
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                trig,
  output logic                                sig_out,
  output logic                                busy,
  output logic [$clog2(PEND_DEPTH+1)-1:0]     pend_cnt,
  output logic                                overflow
);

  localparam int unsigned PW      = $clog2(PEND_DEPTH + 1);
  localparam int unsigned CNT_MAX = (LOW_CYCLES > HIGH_CYCLES) ? LOW_CYCLES : HIGH_CYCLES;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LOW     = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [PW-1:0]   r_pend;
  logic            r_sig;
  logic            r_busy;
  logic            r_ovf;

  logic            w_expire;
  logic            w_pend_nz;
  logic            w_pend_full;
  logic            w_start_pend;
  logic            w_start_fresh;
  logic            w_queue;

  // A trigger starts a pulse directly only from an empty idle state; otherwise it is queued.
  assign w_expire      = (r_state == S_RECOVER) && (r_cnt == '0);
  assign w_pend_nz     = (r_pend != '0);
  assign w_pend_full   = (r_pend == PW'(PEND_DEPTH));
  assign w_start_pend  = w_pend_nz && ((r_state == S_IDLE) || w_expire);
  assign w_start_fresh = trig && (r_state == S_IDLE) && !w_pend_nz;
  assign w_queue       = trig && !w_start_fresh;

  // Pulse FSM with registered line, busy and queue outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pend  <= '0;
      r_sig   <= 1'b1;
      r_busy  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start_pend || w_start_fresh) begin
            r_state <= S_LOW;
            r_cnt   <= CW'(LOW_CYCLES - 1);
            r_sig   <= 1'b0;
            r_busy  <= 1'b1;
          end
        end
        S_LOW: begin
          if (r_cnt == '0) begin
            r_state <= S_RECOVER;
            r_cnt   <= CW'(HIGH_CYCLES - 1);
            r_sig   <= 1'b1;
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        S_RECOVER: begin
          if (r_cnt == '0) begin
            if (w_pend_nz) begin
              r_state <= S_LOW;
              r_cnt   <= CW'(LOW_CYCLES - 1);
              r_sig   <= 1'b0;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          r_sig   <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase

      // Simultaneous queue and consume leaves the count unchanged and never overflows.
      if (w_queue && !w_start_pend) begin
        if (w_pend_full) begin
          r_ovf <= 1'b1;
        end else begin
          r_pend <= r_pend + PW'(1);
        end
      end else if (!w_queue && w_start_pend) begin
        r_pend <= r_pend - PW'(1);
      end
    end
  end

  assign sig_out  = r_sig;
  assign busy     = r_busy;
  assign pend_cnt = r_pend;
  assign overflow = r_ovf;

endmodule
